// File: rtl/steak_cook_tracker.sv
// steak_cook_tracker
// Consumer end of the cook-timer interface for one grill slot. Decodes the
// timer's toggling `go` line into cook ticks and tracks the doneness of both
// sides of one steak through place / flip / serve actions. A serve produces
// a one-cycle scored result.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   go           in   cook-timer toggle; every transition is one cook tick
//   place        in   pulse: put a steak on the grill
//   flip         in   pulse: flip the steak
//   serve        in   pulse: take the steak off and score it
//   cook_en      out  timer enable; low restarts the timer interval
//   side_down    out  0 = side A on the grill, 1 = side B
//   level_a      out  doneness of side A
//   level_b      out  doneness of side B
//   burnt        out  high while the steak is burnt
//   result_valid out  one-cycle pulse when a serve is accepted
//   score        out  3 perfect, 2 half, 1 undercooked/uneven, 0 burnt
//
// All outputs come straight from registers.
module steak_cook_tracker #(
  parameter int LEVEL_W    = 3,
  parameter int BURN_LEVEL = 6,
  parameter int TARGET_LO  = 3,
  parameter int TARGET_HI  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               place,
  input  logic               flip,
  input  logic               serve,
  output logic               cook_en,
  output logic               side_down,
  output logic [LEVEL_W-1:0] level_a,
  output logic [LEVEL_W-1:0] level_b,
  output logic               burnt,
  output logic               result_valid,
  output logic [1:0]         score
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COOK,
    S_FLIP,
    S_BURNT,
    S_DONE
  } state_t;

  localparam logic [LEVEL_W-1:0] BURN_L = LEVEL_W'(BURN_LEVEL);
  localparam logic [LEVEL_W-1:0] LO_L   = LEVEL_W'(TARGET_LO);
  localparam logic [LEVEL_W-1:0] HI_L   = LEVEL_W'(TARGET_HI);

  state_t             state_q;
  logic               go_q;
  logic               cook_en_q;
  logic               side_q;
  logic [LEVEL_W-1:0] lvl_a_q;
  logic [LEVEL_W-1:0] lvl_b_q;
  logic               burnt_q;
  logic               result_valid_q;
  logic [1:0]         score_q;

  // Post-tick levels, burn detection and the score a serve would earn now.
  logic               tick;
  logic [LEVEL_W-1:0] lvl_a_d;
  logic [LEVEL_W-1:0] lvl_b_d;
  logic               hit_burn;
  logic               in_a;
  logic               in_b;
  logic [1:0]         serve_score;

  function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] v);
    return (v >= BURN_L) ? BURN_L : v + LEVEL_W'(1);
  endfunction

  always_comb begin
    tick     = go ^ go_q;
    lvl_a_d  = lvl_a_q;
    lvl_b_d  = lvl_b_q;
    hit_burn = 1'b0;
    // The tick is credited to the side that is down before any flip lands.
    if (state_q == S_COOK && tick) begin
      if (!side_q) begin
        lvl_a_d  = sat_inc(lvl_a_q);
        hit_burn = (lvl_a_d == BURN_L);
      end else begin
        lvl_b_d  = sat_inc(lvl_b_q);
        hit_burn = (lvl_b_d == BURN_L);
      end
    end
    in_a = (lvl_a_d >= LO_L) && (lvl_a_d <= HI_L);
    in_b = (lvl_b_d >= LO_L) && (lvl_b_d <= HI_L);
    if (in_a && in_b)      serve_score = 2'd3;
    else if (in_a || in_b) serve_score = 2'd2;
    else                   serve_score = 2'd1;
  end

  always_ff @(posedge clk) begin
    // Tracks go even during reset so the first cycle after reset sees no tick.
    go_q <= go;
    if (reset) begin
      state_q        <= S_IDLE;
      cook_en_q      <= 1'b0;
      side_q         <= 1'b0;
      lvl_a_q        <= '0;
      lvl_b_q        <= '0;
      burnt_q        <= 1'b0;
      result_valid_q <= 1'b0;
      score_q        <= 2'd0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (place) begin
            state_q   <= S_COOK;
            cook_en_q <= 1'b1;
            side_q    <= 1'b0;
            lvl_a_q   <= '0;
            lvl_b_q   <= '0;
          end
        end
        S_COOK: begin
          lvl_a_q <= lvl_a_d;
          lvl_b_q <= lvl_b_d;
          // Burn beats serve, serve beats flip.
          if (hit_burn) begin
            state_q   <= S_BURNT;
            cook_en_q <= 1'b0;
            burnt_q   <= 1'b1;
          end else if (serve) begin
            state_q        <= S_DONE;
            cook_en_q      <= 1'b0;
            result_valid_q <= 1'b1;
            score_q        <= serve_score;
          end else if (flip) begin
            // One cycle with the enable low clears the timer's count.
            state_q   <= S_FLIP;
            cook_en_q <= 1'b0;
            side_q    <= ~side_q;
          end
        end
        S_FLIP: begin
          state_q   <= S_COOK;
          cook_en_q <= 1'b1;
        end
        S_BURNT: begin
          if (serve) begin
            state_q        <= S_DONE;
            burnt_q        <= 1'b0;
            result_valid_q <= 1'b1;
            score_q        <= 2'd0;
          end
        end
        S_DONE: begin
          if (place) begin
            state_q   <= S_COOK;
            cook_en_q <= 1'b1;
            side_q    <= 1'b0;
            lvl_a_q   <= '0;
            lvl_b_q   <= '0;
            score_q   <= 2'd0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          cook_en_q <= 1'b0;
          burnt_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cook_en      = cook_en_q;
  assign side_down    = side_q;
  assign level_a      = lvl_a_q;
  assign level_b      = lvl_b_q;
  assign burnt        = burnt_q;
  assign result_valid = result_valid_q;
  assign score        = score_q;

endmodule
